qu_uop_queue: RTL and testbench

- Parametrised micro-op queue between the decoder and the issue stage of the Qu processor.
- Buffers up to DEPTH micro-ops of UOP_WIDTH bits each, with valid/ready handshakes on both sides and a synchronous flush.
- Provides total occupancy and the number of queued memory micro-ops (load or store, decoded from the optype field) so the issue stage can throttle against load/store resources.

---
 rtl/qu_uop_queue.sv | 89 ++++++++
 tb/tb_qu_uop_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/qu_uop_queue.sv
// Micro-op queue between decode and issue: circular buffer with occupancy and memory-op counts.
// Optional feature: define QU_UOPQ_BYPASS_EN for an empty-queue combinational bypass.
module qu_uop_queue #(
   parameter int UOP_WIDTH = 60,
   parameter int DEPTH     = 8,
   parameter int CW        = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [UOP_WIDTH-1:0] in_uop,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [UOP_WIDTH-1:0] out_uop,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CW-1:0]        count,
   output logic [CW-1:0]        mem_count,
   output logic                 full,
   output logic                 empty
);

   localparam int PW = $clog2(DEPTH);

   logic [UOP_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        count_q;
   logic [CW-1:0]        mem_count_q;
   logic                 bypass;
   logic                 enq;
   logic                 deq;
   logic                 enq_mem;
   logic                 deq_mem;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign mem_count = mem_count_q;
   assign in_ready  = !full && !flush;

`ifdef QU_UOPQ_BYPASS_EN
   // An empty queue forwards the incoming micro-op; it is stored only if issue stalls.
   assign bypass    = empty && !flush && in_valid;
   assign out_valid = bypass || (!empty && !flush);
   assign out_uop   = bypass ? in_uop : mem[rd_ptr];
   assign enq       = in_valid && in_ready && !(bypass && out_ready);
   assign deq       = out_valid && out_ready && !bypass;
`else
   assign bypass    = 1'b0;
   assign out_valid = !empty && !flush;
   assign out_uop   = mem[rd_ptr];
   assign enq       = in_valid && in_ready;
   assign deq       = out_valid && out_ready;
`endif

   assign enq_mem = enq && in_uop[1];
   assign deq_mem = deq && mem[rd_ptr][1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (enq) begin
         mem[wr_ptr] <= in_uop;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         mem_count_q <= '0;
      end else if (flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         mem_count_q <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         count_q     <= count_q + CW'(enq) - CW'(deq);
         mem_count_q <= mem_count_q + CW'(enq_mem) - CW'(deq_mem);
      end
   end

endmodule

// File: tb/tb_qu_uop_queue.sv
// Bench for qu_uop_queue: queue-based reference model checked every cycle plus directed literal checks.
// Honours QU_UOPQ_BYPASS_EN when defined for the build.
module tb_qu_uop_queue;

   localparam int W  = 60;
   localparam int D  = 8;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic [W-1:0]  in_uop = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  out_uop;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] count;
   logic [CW-1:0] mem_count;
   logic          full;
   logic          empty;

   int n_err = 0;
   int n_chk = 0;

   logic [W-1:0] q[$];
   bit           fresh = 1'b1;
   bit           m_enq = 1'b0;
   bit           m_deq = 1'b0;
   logic [W-1:0] m_uop = '0;

   localparam logic [W-1:0] UL = 60'hAAAA_BBBB_CCCC_002;
   localparam logic [W-1:0] UI = 60'h1111_2222_3333_400;
   localparam logic [W-1:0] US = 60'h9999_8888_7777_603;
   localparam logic [W-1:0] UA = 60'h5555_5555_5555_55A;

   qu_uop_queue #(.UOP_WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_uop(in_uop), .in_valid(in_valid), .in_ready(in_ready),
      .out_uop(out_uop), .out_valid(out_valid), .out_ready(out_ready),
      .count(count), .mem_count(mem_count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] mk(input int i, input logic [1:0] op);
      logic [57:0] tag;
      tag = 58'(i * 37 + 1);
      return {tag, op};
   endfunction

   // Reference: expected outputs derive from queue contents and current inputs.
   always @(negedge clk) begin : cmp
      int           mc;
      bit           e_full, e_empty, e_ir, e_ov, byp;
      logic [W-1:0] e_uop;
      mc = 0;
      foreach (q[i]) if (q[i][1]) mc++;
      if (rst) begin
         chk("rst_in_ready", 64'(in_ready), 64'd1);
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_out_uop", 64'(out_uop), 64'd0);
         chk("rst_count", 64'(count), 64'd0);
         chk("rst_mem_count", 64'(mem_count), 64'd0);
         chk("rst_full", 64'(full), 64'd0);
         chk("rst_empty", 64'(empty), 64'd1);
         m_enq = 1'b0;
         m_deq = 1'b0;
      end else begin
         e_full  = (q.size() == D);
         e_empty = (q.size() == 0);
         e_ir    = !e_full && !flush;
`ifdef QU_UOPQ_BYPASS_EN
         byp = e_empty && !flush && in_valid;
`else
         byp = 1'b0;
`endif
         e_ov  = byp || (!e_empty && !flush);
         e_uop = byp ? in_uop : (e_empty ? '0 : q[0]);
         chk("count", 64'(count), 64'(q.size()));
         chk("mem_count", 64'(mem_count), 64'(mc));
         chk("full", 64'(full), 64'(e_full));
         chk("empty", 64'(empty), 64'(e_empty));
         chk("in_ready", 64'(in_ready), 64'(e_ir));
         chk("out_valid", 64'(out_valid), 64'(e_ov));
         if (e_ov) chk("out_uop", 64'(out_uop), 64'(e_uop));
         else if (fresh) chk("out_uop_idle", 64'(out_uop), 64'd0);
         m_enq = in_valid && e_ir && !(byp && out_ready);
         m_deq = e_ov && out_ready && !byp;
         m_uop = in_uop;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         fresh = 1'b1;
      end else if (flush) begin
         q.delete();
      end else begin
         if (m_deq) void'(q.pop_front());
         if (m_enq) begin
            q.push_back(m_uop);
            fresh = 1'b0;
         end
      end
   end

   task automatic drive(input bit v, input logic [W-1:0] u, input bit r, input bit f);
      in_valid  = v;
      in_uop    = u;
      out_ready = r;
      flush     = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Three ops in, then drained in order
      drive(1, UL, 0, 0);
      drive(1, UI, 0, 0);
      drive(1, US, 0, 0);
      chk("t1_count", 64'(count), 64'd3);
      chk("t1_mem_count", 64'(mem_count), 64'd2);
      chk("t1_head", 64'(out_uop), 64'(UL));
      drive(0, '0, 1, 0);
      chk("t1_second", 64'(out_uop), 64'(UI));
      drive(0, '0, 1, 0);
      chk("t1_mem_after2", 64'(mem_count), 64'd1);
      drive(0, '0, 1, 0);
      chk("t1_count_end", 64'(count), 64'd0);
      chk("t1_mem_end", 64'(mem_count), 64'd0);

      // Fill to DEPTH, reject the ninth, one dequeue reopens input
      for (int i = 0; i < D; i++) drive(1, mk(i, 2'(i)), 0, 0);
      chk("t2_full", 64'(full), 64'd1);
      chk("t2_in_ready", 64'(in_ready), 64'd0);
      drive(1, mk(99, 2'b11), 0, 0);
      chk("t2_count_9th", 64'(count), 64'd8);
      chk("t2_mem_9th", 64'(mem_count), 64'd4);
      drive(0, '0, 1, 0);
      chk("t2_in_ready_after", 64'(in_ready), 64'd1);
      chk("t2_count_after", 64'(count), 64'd7);
      repeat (7) drive(0, '0, 1, 0);
      chk("t2_empty", 64'(empty), 64'd1);

      // Half full streaming: 20 cycles of simultaneous enqueue/dequeue
      for (int i = 0; i < 4; i++) drive(1, mk(100 + i, 2'(i + 1)), 0, 0);
      for (int i = 0; i < 20; i++) drive(1, mk(200 + i, 2'(i)), 1, 0);
      chk("t3_count", 64'(count), 64'd4);
      chk("t3_head", 64'(out_uop), 64'(mk(216, 2'd0)));
      repeat (4) drive(0, '0, 1, 0);

      // Flush with five entries, three of them memory ops
      for (int i = 0; i < 5; i++) drive(1, mk(300 + i, (i < 3) ? 2'b10 : 2'b01), 0, 0);
      chk("t4_mem_count", 64'(mem_count), 64'd3);
      drive(1, mk(400, 2'b11), 1, 1);
      chk("t4_count", 64'(count), 64'd0);
      chk("t4_mem", 64'(mem_count), 64'd0);
      chk("t4_empty", 64'(empty), 64'd1);
      drive(1, mk(401, 2'b10), 1, 1);
      chk("t4_hold_empty", 64'(empty), 64'd1);
      drive(0, '0, 0, 0);

      // Asynchronous reset mid-stream with six entries
      for (int i = 0; i < 6; i++) drive(1, mk(500 + i, 2'b11), 0, 0);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("t5_out_valid", 64'(out_valid), 64'd0);
      chk("t5_count", 64'(count), 64'd0);
      chk("t5_out_uop", 64'(out_uop), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      drive(0, '0, 0, 0);

      // Empty queue with a ready consumer
      in_valid = 1'b1; in_uop = UA; out_ready = 1'b1; flush = 1'b0;
      #1;
`ifdef QU_UOPQ_BYPASS_EN
      chk("t6_byp_valid", 64'(out_valid), 64'd1);
      chk("t6_byp_uop", 64'(out_uop), 64'(UA));
`else
      chk("t6_no_valid", 64'(out_valid), 64'd0);
`endif
      @(posedge clk);
      #1;
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
`ifdef QU_UOPQ_BYPASS_EN
      chk("t6_count", 64'(count), 64'd0);
      chk("t6_valid_after", 64'(out_valid), 64'd0);
`else
      chk("t6_count", 64'(count), 64'd1);
      chk("t6_valid_after", 64'(out_valid), 64'd1);
      chk("t6_uop_after", 64'(out_uop), 64'(UA));
`endif
      drive(0, '0, 1, 0);
      drive(0, '0, 0, 0);
      chk("end_empty", 64'(empty), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
